// File: rtl/commit_stage.sv
// commit_stage: final pipeline stage that commits RF/CSR writes and turns exceptions into traps or mret returns
//   Optional feature: define COMMIT_INSTRET_EN to add the 64-bit instret counter and port.
//   clk, nrst                      clock, asynchronous active-low reset
//   wb_data6, we6, rd6             register-file write request from stage 6
//   csr_wb, csr_wb_addr, csr_we6   CSR write request from stage 6
//   pc6, cause6                    PC (word index) and trap cause of the stage-6 instruction
//   exception_pending, mret6       trap/return request and mret flag
//   mtvec, mepc                    trap vector and return PC from the CSR file
//   rf_we, rf_waddr, rf_wdata      registered register-file write port
//   csr_we, csr_waddr, csr_wdata   registered CSR write port
//   trap_we, trap_epc, trap_cause  one-cycle mepc/mcause update
//   redirect, redirect_pc          one-cycle fetch redirect
//   excep6                         upstream flush, high while draining after a redirect
//   instret                        retired-write counter (COMMIT_INSTRET_EN only)
module commit_stage #(
  parameter int XLEN = 32,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [XLEN-1:0] wb_data6,
  input  logic            we6,
  input  logic [4:0]      rd6,
  input  logic [XLEN-1:0] csr_wb,
  input  logic [11:0]     csr_wb_addr,
  input  logic            csr_we6,
  input  logic [XLEN-1:0] pc6,
  input  logic [XLEN-1:0] cause6,
  input  logic            exception_pending,
  input  logic            mret6,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            trap_we,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_cause,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            excep6
`ifdef COMMIT_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic take, is_ret, vec, run_wr;
  logic [XLEN-1:0] vec_pc;
  always_comb begin
    take    = state == RUN && exception_pending;
    run_wr  = state == RUN && !exception_pending;
    is_ret  = mret6 && cause6 == '0;
    vec     = mtvec[0] && cause6[XLEN-1];
    // mtvec is already in word units once the mode bits are shifted out
    vec_pc  = (mtvec >> 2) + (vec ? {1'b0, cause6[XLEN-2:0]} : '0);
    state_n = take ? FLUSH : (state == FLUSH && cnt == 4'd0) ? RUN : state;
    cnt_n   = take ? 4'(FLUSH_CYCLES - 1) : (state == FLUSH && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  end
  assign excep6 = state == FLUSH;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= RUN;
      cnt         <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      csr_we      <= 1'b0;
      csr_waddr   <= '0;
      csr_wdata   <= '0;
      trap_we     <= 1'b0;
      trap_epc    <= '0;
      trap_cause  <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rf_we       <= run_wr && we6 && rd6 != 5'd0;
      rf_waddr    <= rd6;
      rf_wdata    <= wb_data6;
      csr_we      <= run_wr && csr_we6;
      csr_waddr   <= csr_wb_addr;
      csr_wdata   <= csr_wb;
      trap_we     <= take && !is_ret;
      trap_epc    <= pc6;
      trap_cause  <= cause6;
      redirect    <= take;
      redirect_pc <= is_ret ? mepc : vec_pc;
    end
  end
`ifdef COMMIT_INSTRET_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) instret <= '0;
    else instret <= instret + 64'(rf_we || csr_we);
  end
`endif
endmodule

// File: tb/tb_commit_stage.sv
// tb_commit_stage: table, directed and random checks of commit_stage against a cycle-count model
module tb_commit_stage;
  localparam int FC = 3;
  logic clk = 0, nrst = 0;
  logic [31:0] wb_data6, csr_wb, pc6, cause6, mtvec, mepc;
  logic we6, csr_we6, exception_pending, mret6;
  logic [4:0] rd6;
  logic [11:0] csr_wb_addr;
  logic rf_we, csr_we, trap_we, redirect, excep6;
  logic [4:0] rf_waddr;
  logic [11:0] csr_waddr;
  logic [31:0] rf_wdata, csr_wdata, trap_epc, trap_cause, redirect_pc;
`ifdef COMMIT_INSTRET_EN
  logic [63:0] instret;
`endif
  int vectors = 0, miscompares = 0;
  int busy = 0;
  longint m_instret = 0;
  logic last_wr = 0;

  commit_stage #(.XLEN(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .nrst(nrst), .wb_data6(wb_data6), .we6(we6), .rd6(rd6),
    .csr_wb(csr_wb), .csr_wb_addr(csr_wb_addr), .csr_we6(csr_we6), .pc6(pc6),
    .cause6(cause6), .exception_pending(exception_pending), .mret6(mret6),
    .mtvec(mtvec), .mepc(mepc), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .trap_we(trap_we), .trap_epc(trap_epc),
    .trap_cause(trap_cause), .redirect(redirect), .redirect_pc(redirect_pc),
    .excep6(excep6)
`ifdef COMMIT_INSTRET_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [4:0] rd; logic [31:0] wd;
    logic cwe; logic [11:0] ca; logic [31:0] cd;
    logic [31:0] pc, cause; logic exc, mret; logic [31:0] tvec, epc;
    logic e_rf, e_csr, e_trap, e_red; logic [31:0] e_rpc;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    {we6, csr_we6, exception_pending, mret6} = '0;
    rd6 = '0; wb_data6 = '0; csr_wb = '0; csr_wb_addr = '0;
    pc6 = '0; cause6 = '0; mtvec = '0; mepc = '0;
  endtask

  task automatic set_vec(input vec_t v);
    we6 = v.we; rd6 = v.rd; wb_data6 = v.wd; csr_we6 = v.cwe; csr_wb_addr = v.ca;
    csr_wb = v.cd; pc6 = v.pc; cause6 = v.cause; exception_pending = v.exc;
    mret6 = v.mret; mtvec = v.tvec; mepc = v.epc;
  endtask

  // One clock: predict from the spec rules, advance, compare
  task automatic step();
    logic free, e_rf, e_csr, e_red, e_trap, ret;
    logic [31:0] e_pc, e_epc, e_cause, e_wd, e_cd;
    logic [4:0] e_rd;
    logic [11:0] e_ca;
    free    = busy == 0;
    ret     = mret6 && cause6 == 0;
    e_rf    = free && !exception_pending && we6 && rd6 != 0;
    e_csr   = free && !exception_pending && csr_we6;
    e_red   = free && exception_pending;
    e_trap  = e_red && !ret;
    e_pc    = ret ? mepc : (mtvec / 4) + ((mtvec[0] && cause6[31]) ? (cause6 & 32'h7fffffff) : 0);
    e_epc = pc6; e_cause = cause6; e_wd = wb_data6; e_rd = rd6; e_ca = csr_wb_addr; e_cd = csr_wb;
    busy = e_red ? FC : (busy > 0 ? busy - 1 : 0);
    m_instret += longint'(last_wr);
    last_wr = e_rf || e_csr;
    @(posedge clk); #1;
    chk("rf_we", rf_we, e_rf);
    if (e_rf) begin chk("rf_waddr", rf_waddr, e_rd); chk("rf_wdata", rf_wdata, e_wd); end
    chk("csr_we", csr_we, e_csr);
    if (e_csr) begin chk("csr_waddr", csr_waddr, e_ca); chk("csr_wdata", csr_wdata, e_cd); end
    chk("trap_we", trap_we, e_trap);
    if (e_trap) begin chk("trap_epc", trap_epc, e_epc); chk("trap_cause", trap_cause, e_cause); end
    chk("redirect", redirect, e_red);
    if (e_red) chk("redirect_pc", redirect_pc, e_pc);
    chk("excep6", excep6, busy > 0);
`ifdef COMMIT_INSTRET_EN
    chk("instret", instret, m_instret);
`endif
  endtask

  task automatic drain();
    idle();
    for (int g = 0; g < 20 && busy > 0; g++) step();
  endtask

  task automatic do_reset();
    nrst = 0; busy = 0; m_instret = 0; last_wr = 0;
    idle();
    @(posedge clk); #1;
    chk("rst_rf_we", rf_we, 0); chk("rst_csr_we", csr_we, 0); chk("rst_trap_we", trap_we, 0);
    chk("rst_redirect", redirect, 0); chk("rst_rpc", redirect_pc, 0); chk("rst_excep6", excep6, 0);
`ifdef COMMIT_INSTRET_EN
    chk("rst_instret", instret, 0);
`endif
    nrst = 1;
  endtask

  initial begin
    int n, reds;
    tv[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    tv[1] = '{1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2] = '{0, 0, 0, 1, 12'h305, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    tv[3] = '{1, 7, 1, 0, 0, 0, 32'h40, 2, 1, 0, 32'h100, 0, 0, 0, 1, 1, 32'h40};
    tv[4] = '{0, 0, 0, 0, 0, 0, 32'h40, 32'h8000000B, 1, 0, 32'h101, 0, 0, 0, 1, 1, 32'h4B};
    tv[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20, 0, 0, 0, 1, 32'h20};
    tv[6] = '{0, 0, 0, 0, 0, 0, 32'h44, 32'h80000007, 1, 1, 32'h100, 32'h20, 0, 0, 1, 1, 32'h40};
    tv[7] = '{1, 3, 32'h55, 1, 12'h300, 32'h66, 8, 5, 1, 0, 32'h101, 0, 0, 0, 1, 1, 32'h40};
    tv[8] = '{0, 0, 0, 0, 0, 0, 0, 32'h80000007, 1, 1, 32'h101, 32'h20, 0, 0, 1, 1, 32'h47};
    tv[9] = '{1, 31, 32'hA5A5, 1, 12'h7FF, 32'hFFFF, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    idle();
    #2 do_reset();

    foreach (tv[i]) begin
      set_vec(tv[i]);
      step();
      chk($sformatf("tv%0d_rf_we", i), rf_we, tv[i].e_rf);
      chk($sformatf("tv%0d_csr_we", i), csr_we, tv[i].e_csr);
      chk($sformatf("tv%0d_trap_we", i), trap_we, tv[i].e_trap);
      chk($sformatf("tv%0d_redirect", i), redirect, tv[i].e_red);
      if (tv[i].e_red) chk($sformatf("tv%0d_rpc", i), redirect_pc, tv[i].e_rpc);
      idle();
      step();
      chk($sformatf("tv%0d_rf_we_1cyc", i), rf_we, 0);
      drain();
    end

    // Flush length and ignored inputs while draining
    set_vec(tv[3]);
    step();
    n = excep6 ? 1 : 0; reds = 0;
    for (int g = 0; g < 20 && busy > 0; g++) begin
      exception_pending = 1; we6 = 1; rd6 = 5'd9; csr_we6 = 1; cause6 = 2;
      step();
      if (excep6) n++;
      if (redirect || rf_we || csr_we) reds++;
    end
    chk("flush_len", n, FC);
    chk("flush_ignored", reds, 0);
    drain();

    // Asynchronous reset in the middle of a flush
    set_vec(tv[4]);
    step();
    idle();
    step();
    #2 nrst = 0;
    #1;
    chk("mid_rst_excep6", excep6, 0); chk("mid_rst_redirect", redirect, 0);
    chk("mid_rst_rpc", redirect_pc, 0); chk("mid_rst_trap_epc", trap_epc, 0);
    busy = 0; m_instret = 0; last_wr = 0;
    @(posedge clk); #1 nrst = 1;
    we6 = 1; rd6 = 5'd4; wb_data6 = 32'h1357;
    step();
    chk("post_rst_commit", rf_we, 1);
    idle();
    step();

`ifdef COMMIT_INSTRET_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i % 2 == 0) begin we6 = 1; rd6 = 5'(i + 1); end
      else begin csr_we6 = 1; csr_wb_addr = 12'(i); end
      step();
    end
    set_vec(tv[3]);
    step();
    drain();
    step();
    chk("instret_10", instret, 10);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      we6 = 1'($urandom); rd6 = 5'($urandom_range(0, 31)); wb_data6 = $urandom;
      csr_we6 = 1'($urandom); csr_wb_addr = 12'($urandom); csr_wb = $urandom;
      pc6 = $urandom; mepc = $urandom; mtvec = $urandom;
      exception_pending = $urandom_range(0, 5) == 0;
      mret6 = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 2))
        0: cause6 = 0;
        1: cause6 = $urandom_range(1, 15);
        default: cause6 = 32'h80000000 | $urandom_range(0, 15);
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/commit_stage.md
# commit_stage

Final pipeline stage, directly downstream of the execute stage. Registers stage-6 results into the integer register file and CSR file write ports, and turns `exception_pending` into a precise trap or an `mret` return. A small FSM flushes the upstream pipes for a fixed number of cycles after every redirect. Drives the `excep6` flush input of the execute stage.

## Interface
- `XLEN`, 32: datapath width.
- `FLUSH_CYCLES`, 3: cycles `excep6` is held after a redirect. Legal range is 1..15.
- `clk` in 1: clock. All state updates on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `wb_data6` in 32: result to write back to the register file.
- `we6` in 1: register-file write request.
- `rd6` in 5: destination register.
- `csr_wb` in 32: CSR write data.
- `csr_wb_addr` in 12: CSR write address.
- `csr_we6` in 1: CSR write request.
- `pc6` in 32: PC of the stage-6 instruction, in word-index units.
- `cause6` in 32: trap cause. Bit 31 set means interrupt.
- `exception_pending` in 1: a trap or return is requested this cycle.
- `mret6` in 1: stage-6 instruction is `mret`.
- `mtvec` in 32: trap vector, from the CSR file.
- `mepc` in 32: return PC, from the CSR file, in word-index units.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `csr_we` out 1, `csr_waddr` out 12, `csr_wdata` out 32: CSR write port.
- `trap_we` out 1: one-cycle pulse that writes `mepc` and `mcause`.
- `trap_epc` out 32, `trap_cause` out 32: values written on `trap_we`.
- `redirect` out 1, `redirect_pc` out 32: one-cycle fetch redirect.
- `excep6` out 1: flush request to all upstream pipe registers.
- `instret` out 64: retired-write counter. Present only with the macro described under Configuration.

## Operation
- FSM states:
  - RUN: normal commit.
  - FLUSH: redirect issued, upstream pipes draining.
- In RUN, with no `exception_pending`:
  - Next cycle: `rf_we` = `we6 && rd6 != 0`, `rf_waddr` = `rd6`, `rf_wdata` = `wb_data6`.
  - Next cycle: `csr_we` = `csr_we6`, with address and data taken from `csr_wb_addr` and `csr_wb`.
  - Writes to x0 are dropped.
- In RUN, with `exception_pending`, a return is taken when `mret6 && cause6 == 0`:
  - `redirect_pc` = `mepc`.
  - No `trap_we`.
- In RUN, with `exception_pending` and any other condition, a trap is taken:
  - `trap_we` pulses, with `trap_epc` = `pc6` and `trap_cause` = `cause6`.
  - If `mtvec[0] == 1` and `cause6[31] == 1` (vectored interrupt): `redirect_pc` = `mtvec[31:2] + cause6[30:0]`.
  - Otherwise: `redirect_pc` = `mtvec[31:2]`.
  - Sums wrap modulo 2^32.
- Whenever `exception_pending` is taken, return or trap:
  - The stage-6 instruction's RF and CSR writes are suppressed.
  - `redirect` pulses.
  - `excep6` asserts.
  - The FSM enters FLUSH with a 4-bit counter loaded to `FLUSH_CYCLES - 1`.
- In FLUSH:
  - `excep6` stays high.
  - All write and trap inputs are ignored, including a new `exception_pending`.
  - The counter decrements. When it is 0, the next state is RUN.

## Timing
- Register-file and CSR writes: inputs sampled at edge N produce write strobes during cycle N+1. Strobes are single-cycle and registered.
- Redirect: `exception_pending` sampled at edge N produces `redirect`, `trap_we` and `excep6` high during cycle N+1.
- `excep6` is high for exactly `FLUSH_CYCLES` cycles (N+1 .. N+FLUSH_CYCLES). The first sampled commit is at edge N+FLUSH_CYCLES+1.
- Back-to-back traps are impossible: at least `FLUSH_CYCLES` cycles separate two `redirect` pulses.
- Reset, asynchronous and mid-operation:
  - Every output goes to 0, including `instret`.
  - State goes to RUN and the counter to 0.
  - A pending redirect or flush is abandoned.
- Simultaneous `we6`, `csr_we6` and `exception_pending`: the exception wins and no write occurs.
- Interrupt coinciding with `mret6` (`cause6 != 0`): trap taken, `mret` discarded.

## Configuration
- `COMMIT_INSTRET_EN` defined:
  - `instret` increments by 1 on every cycle where `rf_we || csr_we` is asserted.
  - 64-bit counter, wraps to 0 after 2^64-1.
  - Never increments on trap or return cycles.
- `COMMIT_INSTRET_EN` undefined: the `instret` port and the counter are absent.

## Test plan
- `we6`=1, `rd6`=5, `wb_data6`=0xDEADBEEF -> next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF, one cycle only. Repeat with `rd6`=0 -> `rf_we` stays 0.
- `exception_pending`=1, `cause6`=2, `pc6`=0x40, `mtvec`=0x100, `we6`=1 -> next cycle:
  - `trap_we`=1, `trap_epc`=0x40, `trap_cause`=2.
  - `redirect_pc`=0x40, `rf_we`=0.
  - `excep6` high exactly 3 cycles.
- `mtvec`=0x101, `cause6`=0x8000000B -> `redirect_pc`=0x40+0xB=0x4B.
- `mret6`=1, `cause6`=0, `mepc`=0x20 -> `redirect_pc`=0x20, `trap_we`=0. Same with `cause6`=0x80000007 -> trap taken instead.
- During FLUSH, drive `exception_pending` and `we6` every cycle -> no second `redirect`, no writes. Assert `nrst`=0 mid-flush -> all outputs 0 immediately, RUN after release.
- With `COMMIT_INSTRET_EN`, 10 committed writes plus 1 trap -> `instret`=10.
